xslidedeaccum: RTL

- Inverse of the slide-window accumulator. Takes the stream of N-sample moving sums S[n] = x[n] + ... + x[n-N+1] and reconstructs the original samples.
- Reconstruction is the recursion x[n] = S[n] - S[n-1] + x[n-N].
- Sits on the receive side of any link that carries windowed sums, e.g. for verification loopback or for rate-reduced transport.
- Uses a circular history buffer and a 2-stage pipeline.

---
 rtl/xslidedeaccum.sv | 111 +++++++++++
 1 files changed

// File: rtl/xslidedeaccum.sv
// Reconstructs samples from an N-sample moving-sum stream via x[n] = S[n] - S[n-1] + x[n-N].
// Two-stage pipeline: stage 1 differences consecutive sums; stage 2 adds the sample from N positions back.
module xslidedeaccum #(
    parameter  int BWID     = 16,
    parameter  int NWINDOWS = 64,
    localparam int BWIDIN   = $clog2(NWINDOWS + 1) - 1 + BWID,
    localparam int PW       = $clog2(NWINDOWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BWIDIN-1:0] iDin,
    input  logic              iND,
    input  logic              iClr,
    output logic [BWID-1:0]   oDout,
    output logic              oDV,
    output logic              oErr
);

    logic [BWIDIN-1:0]   prev_q, prev_d;
    logic [BWID:0]       diff_q, diff_d;
    logic                vld1_q, vld1_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NWINDOWS-1:0] hvld_q, hvld_d;
    logic [BWID-1:0]     dout_q, dout_d;
    logic                dv_q, dv_d;
    logic                err_q, err_d;

    logic [BWID:0]       hist_q [NWINDOWS];
    logic                hist_we;
    logic [BWID:0]       hist_rd;
    logic [BWIDIN-1:0]   diff_full;
    logic [BWID+1:0]     x_sum;
    logic                x_ovf;
    logic                diff_unused;

    // Only the low BWID+1 bits of the modular difference carry information.
    assign diff_full   = iDin - prev_q;
    assign diff_unused = ^diff_full;

    // Entries not written since reset/clear read as zero via their valid bit.
    assign hist_rd = hvld_q[ptr_q] ? hist_q[ptr_q] : '0;
    assign x_sum   = {diff_q[BWID], diff_q} + {hist_rd[BWID], hist_rd};
    assign x_ovf   = !((x_sum[BWID+1:BWID-1] == '0) || (x_sum[BWID+1:BWID-1] == '1));

    always_comb begin
        prev_d  = prev_q;
        diff_d  = diff_q;
        vld1_d  = 1'b0;
        ptr_d   = ptr_q;
        hvld_d  = hvld_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        err_d   = err_q;
        hist_we = 1'b0;
        if (iClr) begin
            prev_d = '0;
            ptr_d  = '0;
            hvld_d = '0;
            err_d  = 1'b0;
        end else begin
            if (iND) begin
                diff_d = diff_full[BWID:0];
                prev_d = iDin;
                vld1_d = 1'b1;
            end
            if (vld1_q) begin
                hist_we       = 1'b1;
                hvld_d[ptr_q] = 1'b1;
                ptr_d         = (ptr_q == PW'(NWINDOWS - 1)) ? '0 : ptr_q + PW'(1);
                dout_d        = x_sum[BWID-1:0];
                dv_d          = 1'b1;
                if (x_ovf) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
            diff_q <= '0;
            vld1_q <= 1'b0;
            ptr_q  <= '0;
            hvld_q <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            diff_q <= diff_d;
            vld1_q <= vld1_d;
            ptr_q  <= ptr_d;
            hvld_q <= hvld_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_q[ptr_q] <= x_sum[BWID:0];
        end
    end

    assign oDout = dout_q;
    assign oDV   = dv_q;
    assign oErr  = err_q;

endmodule
